// File: rtl/sect571k1_pkg.sv
// Shared sect571k1 / GF(2^571) constants, FSM state type and generator point.
package sect571k1_pkg;

  localparam int unsigned M = 571;

  // Low part of f(z) = z^571 + z^10 + z^5 + z^2 + 1
  localparam logic [M-1:0] RED_POLY = {{(M-11){1'b0}}, 11'h425};

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, CMP} state_e;

  localparam logic [M-1:0] GX = 571'h26EB7A8_59923FBC_82189631_F8103FE4_AC9CA297_0012D5D4_60248048_01841CA4_43709584_93B205E6_47DA304D_B4CEB08C_BBD1BA39_494776FB_988B4717_4DCA88C7_E2945283_A01C8972;
  localparam logic [M-1:0] GY = 571'h349DC80_7F4FBF37_4F4AEADE_3BCA9531_4DD58CEC_9F307A54_FFC61EFC_006D8A2C_9D4979C0_AC44AEA7_4FBEBBB9_F772AEDC_B620B01A_7BA7AF1B_320430C8_591984F6_01CD4C14_3EF1C7A3;

endpackage

// File: rtl/gf2m571_mul_serial.sv
// MSB-first bit-serial GF(2^571) multiplier, one operand bit per cycle.
// The load cycle already consumes b[570], so a product takes 571 edges in total.
module gf2m571_mul_serial
  import sect571k1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         rdy,
  output logic [M-1:0] p
);

  localparam logic [9:0] FIRST_CNT = 10'(M - 2);

  logic [M-1:0] acc_q, a_q, b_q;
  logic [9:0]   cnt_q;
  logic         busy_q, rdy_q;

  function automatic logic [M-1:0] mulz(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? RED_POLY : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (clr) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= b[M-1] ? a : '0;
      a_q    <= a;
      b_q    <= {b[M-2:0], 1'b0};
      cnt_q  <= FIRST_CNT;
      busy_q <= 1'b1;
      rdy_q  <= 1'b0;
    end else if (busy_q) begin
      acc_q <= mulz(acc_q) ^ (b_q[M-1] ? a_q : '0);
      b_q   <= {b_q[M-2:0], 1'b0};
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
        rdy_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 10'd1;
      end
    end else begin
      rdy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign rdy  = rdy_q;
  assign p    = acc_q;

endmodule

// File: rtl/sect571k1_pt_chk.sv
// sect571k1 point-on-curve checker: tests y*(x+y) == x^3 + 1 with one serial multiplier.
// Optional: SECT571K1_PT_CHK_INF_EN reports (0,0) as the point at infinity (valid = 1).
module sect571k1_pt_chk
  import sect571k1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic         done,
  output logic         valid
);

  state_e       state_q;
  logic [M-1:0] rx_q, ry_q, t0_q, t1_q, t2_q;
  logic         done_q, valid_q;

  logic         mul_load, mul_busy, mul_rdy;
  logic [M-1:0] op_a, op_b, mul_p;
  logic         eq, on_curve;

  // Each product's completion edge also launches the next one, so the
  // three multiplies run back to back; MUL3 takes t1 straight from p.
  always_comb begin
    mul_load = 1'b0;
    op_a     = ry_q;
    op_b     = rx_q ^ ry_q;
    case (state_q)
      MUL1: begin
        if (mul_rdy) begin
          mul_load = 1'b1;
          op_a     = rx_q;
          op_b     = rx_q;
        end else if (!mul_busy) begin
          mul_load = 1'b1;
        end
      end
      MUL2: begin
        if (mul_rdy) begin
          mul_load = 1'b1;
          op_a     = mul_p;
          op_b     = rx_q;
        end
      end
      default: ;
    endcase
  end

  gf2m571_mul_serial u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (mul_load),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .rdy   (mul_rdy),
    .p     (mul_p)
  );

  assign eq = (t0_q == (t2_q ^ {{(M-1){1'b0}}, 1'b1}));
`ifdef SECT571K1_PT_CHK_INF_EN
  assign on_curve = eq | ((rx_q == '0) & (ry_q == '0));
`else
  assign on_curve = eq;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rx_q    <= '0;
      ry_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rx_q    <= x;
            ry_q    <= y;
            valid_q <= 1'b0;
            state_q <= MUL1;
          end
        end
        MUL1: begin
          if (mul_rdy) begin
            t0_q    <= mul_p;
            state_q <= MUL2;
          end
        end
        MUL2: begin
          if (mul_rdy) begin
            t1_q    <= mul_p;
            state_q <= MUL3;
          end
        end
        MUL3: begin
          if (mul_rdy) begin
            t2_q    <= mul_p;
            state_q <= CMP;
          end
        end
        CMP: begin
          valid_q <= on_curve;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_sect571k1_pt_chk.sv
// Bench for sect571k1_pt_chk: field-arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_sect571k1_pt_chk;
  import sect571k1_pkg::*;

  localparam int unsigned LAT = 1715;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr   = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] x     = '0;
  logic [M-1:0] y     = '0;
  logic         done, valid;

  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;

  logic         m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0, m_pend = 1'b0;
  int           m_left = 0;

  sect571k1_pt_chk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .start (start),
    .x     (x),
    .y     (y),
    .done  (done),
    .valid (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- field / curve reference ----------------
  function automatic logic [M-1:0] xt(input logic [M-1:0] v);
    logic [M-1:0] r;
    r = v << 1;
    if (v[M-1]) r = r ^ RED_POLY;
    return r;
  endfunction

  // LSB-first schoolbook product
  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r, s;
    r = '0;
    s = a;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) r = r ^ s;
      s = xt(s);
    end
    return r;
  endfunction

  // a^(2^571 - 2)
  function automatic logic [M-1:0] ginv(input logic [M-1:0] a);
    logic [M-1:0] r, s;
    r = '0;
    r[0] = 1'b1;
    s = a;
    for (int i = 1; i < int'(M); i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic on_curve_m(input logic [M-1:0] px, input logic [M-1:0] py);
    logic [M-1:0] one;
    one = '0;
    one[0] = 1'b1;
`ifdef SECT571K1_PT_CHK_INF_EN
    if (px == '0 && py == '0) return 1'b1;
`endif
    return gmul(py, px ^ py) == (gmul(gmul(px, px), px) ^ one);
  endfunction

  task automatic pt_dbl(input logic [M-1:0] px, input logic [M-1:0] py,
                        output logic [M-1:0] qx, output logic [M-1:0] qy);
    logic [M-1:0] lam, one;
    one = '0;
    one[0] = 1'b1;
    lam = px ^ gmul(py, ginv(px));
    qx  = gmul(lam, lam) ^ lam;
    qy  = gmul(px, px) ^ gmul(lam ^ one, qx);
  endtask

  task automatic pt_add(input logic [M-1:0] ax, input logic [M-1:0] ay,
                        input logic [M-1:0] bx, input logic [M-1:0] by,
                        output logic [M-1:0] qx, output logic [M-1:0] qy);
    logic [M-1:0] lam;
    lam = gmul(ay ^ by, ginv(ax ^ bx));
    qx  = gmul(lam, lam) ^ lam ^ ax ^ bx;
    qy  = gmul(lam, ax ^ qx) ^ qx ^ ay;
  endtask

  // Transaction-level model: accept start when free, answer LAT edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (clr) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_valid <= m_pend;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy  <= 1'b1;
        m_left  <= LAT;
        m_pend  <= on_curve_m(x, y);
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      chk("cycle done", M'(done), M'(m_done));
      chk("cycle valid", M'(valid), M'(m_valid));
    end
  endtask

  task automatic pulse_start(input logic [M-1:0] px, input logic [M-1:0] py,
                             output int unsigned t0);
    @(posedge clk);
    #1;
    x = px;
    y = py;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    x = ~px;
    y = ~py;
  endtask

  task automatic wait_done(input int unsigned t0, input logic expv, input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, " done"}, M'(seen), M'(1));
    if (seen) begin
      chk({name, " latency"}, M'(cyc - t0), M'(LAT));
      chk({name, " valid"}, M'(valid), M'(expv));
    end
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run(input logic [M-1:0] px, input logic [M-1:0] py,
                     input logic expv, input string name);
    int unsigned t0;
    pulse_start(px, py, t0);
    wait_done(t0, expv, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [M-1:0] va, vb, one, two, g2x, g2y, g3x, g3y;
    logic         inf_exp;
    int unsigned  t0;
    int           cnt;

    one = '0; one[0] = 1'b1;
    two = '0; two[1] = 1'b1;

    // Model pins
    va = '0; va[570] = 1'b1;
    chk("pin z570*z", gmul(va, two), RED_POLY);
    chk("pin G on curve", M'(on_curve_m(GX, GY)), M'(1));
    chk("pin G^1 off curve", M'(on_curve_m(GX, GY ^ one)), M'(0));
    chk("pin (0,2)", M'(on_curve_m('0, two)), M'(0));
    chk("pin (0,1)", M'(on_curve_m('0, one)), M'(1));
    chk("pin (1,0)", M'(on_curve_m(one, '0)), M'(1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset done", M'(done), M'(0));
    chk("reset valid", M'(valid), M'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    fork
      monitor();
    join_none

`ifdef SECT571K1_PT_CHK_INF_EN
    inf_exp = 1'b1;
`else
    inf_exp = 1'b0;
`endif

    run(GX, GY, 1'b1, "G");
    run(GX, GY ^ one, 1'b0, "G^1");
    run('0, two, 1'b0, "(0,2)");
    run('0, one, 1'b1, "(0,1)");
    run(one, '0, 1'b1, "(1,0)");
    run('0, '0, inf_exp, "(0,0)");

    // Second start while busy must be ignored
    pulse_start(GX, GY, t0);
    repeat (99) @(posedge clk);
    #1;
    x = '0;
    y = two;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(t0, 1'b1, "ignored start");
    count_done(1800, cnt);
    chk("ignored start extra done", M'(cnt), M'(0));

    // Abort by reset
    run(GX, GY ^ one, 1'b0, "pre-abort");
    pulse_start(GX, GY, t0);
    repeat (899) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst abort done", M'(done), M'(0));
    chk("rst abort valid", M'(valid), M'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    count_done(1000, cnt);
    chk("rst abort no done", M'(cnt), M'(0));

    // Abort by clr
    run(GX, GY, 1'b1, "pre-clr");
    pulse_start(GX, GY, t0);
    repeat (899) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr abort done", M'(done), M'(0));
    chk("clr abort valid", M'(valid), M'(0));
    count_done(1000, cnt);
    chk("clr abort no done", M'(cnt), M'(0));

    run(GX, GY, 1'b1, "fresh after abort");

    // Multiples of G: 2G, 3G and (n-1)G = -G
    pt_dbl(GX, GY, g2x, g2y);
    pt_add(g2x, g2y, GX, GY, g3x, g3y);
    run(g2x, g2y, 1'b1, "2G");
    run(g3x, g3y, 1'b1, "3G");
    run(GX, GX ^ GY, 1'b1, "(n-1)G");

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sect571k1_pt_chk.md
# sect571k1_pt_chk

Point-on-curve checker for sect571k1 (y² + xy = x³ + 1 over GF(2^571), f(z) = z^571 + z^10 + z^5 + z^2 + 1). It sits on the consumer side of `sect571k1_pt_mul`: it accepts an affine point (x, y), such as a multiplier result or an externally supplied public key, and reports whether the point satisfies the curve equation. It uses the same clr/start/done handshake style as the multiplier and reuses a bit-serial GF(2^571) multiplier.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear; aborts any check, returns to idle
- start  input  1  one-cycle pulse; samples x, y
- x  input  571  affine x coordinate
- y  input  571  affine y coordinate
- done  output  1  one-cycle pulse when the result is ready
- valid  output  1  result: 1 = point on curve; held until next start accepted or clr

## Operation
- Identity used: y·(x + y) = x³ + 1 (a = 0, b = 1). Addition is bitwise XOR.
- States:
  - IDLE: waits for start; on start, latches x→rx, y→ry, clears valid, loads MUL1.
  - MUL1: t0 = ry·(rx ⊕ ry).
  - MUL2: t1 = rx·rx.
  - MUL3: t2 = t1·rx.
  - CMP: valid = (t0 == t2 ⊕ 1); pulses done; returns to IDLE.
- Multiplier algorithm: MSB-first bit-serial. acc starts at 0. For i = 570 down to 0: acc = (acc·z mod f) ⊕ (b[i] ? a : 0). Reduction: shift left; if the bit shifted out of position 570 was 1, XOR 0x425 into bits [10:0].
- Operands are 571 bits wide, so all inputs are already reduced. No range check is done.
- start while not in IDLE: ignored. The latched operands are not disturbed.
- clr: synchronous, has priority over start. It forces IDLE, done = 0, valid = 0 and clears the multiplier accumulator.
- Reset (rst_n low) at any time, including mid-check: immediately forces IDLE. All registers are cleared.

## Timing
- Reset values: done = 0, valid = 0, state IDLE, rx/ry/t0/t1/t2 = 0.
- Each multiplication takes 571 cycles (one bit per cycle).
- Latency: done is high in the cycle beginning 1715 rising edges after the edge that samples start (1 load + 3×571 + 1 compare).
- valid updates on the same edge that raises done, and stays stable after done falls.
- Back-to-back operation: start is accepted in the cycle after done. Throughput is one check per 1716 cycles.
- x and y only need to be stable in the start cycle.

## Configuration
- `SECT571K1_PT_CHK_INF_EN` defined: the input (0, 0) encodes the point at infinity. It is reported valid = 1, with done at the normal 1715-cycle latency; the full multiply sequence still runs so timing is constant.
- Macro undefined: (0, 0) goes through the equation unchanged (0 ≠ 1) and is reported valid = 0.

## Structure
- Package `sect571k1_pkg` holds:
  - M = 571
  - reduction constant 0x425
  - the state enum (IDLE, MUL1, MUL2, MUL3, CMP)
  - the generator constants Gx and Gy, shared with the multiplier bench
- Sub-module `gf2m571_mul_serial` contains:
  - ports: clk, rst_n, clr, load, a[570:0], b[570:0]
  - outputs: busy, rdy, p[570:0]
  - the bit counter and accumulator
- The top level is the FSM plus operand muxing.

## Test plan
- (x, y) = (Gx, Gy), the sect571k1 generator from SEC 2 → done at +1715 cycles, valid = 1.
- (Gx, Gy ⊕ 1) → valid = 0. (0, 2) → valid = 0. (0, 1) → valid = 1. (1, 0) → valid = 1.
- (0, 0) → valid = 0 without the macro; valid = 1 with `SECT571K1_PT_CHK_INF_EN`.
- start (Gx, Gy), second start with (0, 2) at +100 cycles → the second start is ignored; a single done at +1715 with valid = 1.
- Check (Gx, Gy ⊕ 1) for a known 0 result, then start (Gx, Gy) and assert rst_n low at +900 cycles for 2 cycles → done = 0 and valid = 0 immediately; no done pulse follows. Repeat with clr at +900 → same result. A fresh start afterwards completes normally with valid = 1.
- Chained: pt_mul output for d = 2, 3 and the n−1 scalars fed directly into the checker → valid = 1 for every point.
